// File: rtl/bcd_scan_ctrl.sv
// Time-shares one external BCD-to-7-segment decoder across NDIG digits, scanning
// MSD first and capturing each decoded result into a per-digit segment register.
module bcd_scan_ctrl #(
  parameter int NDIG    = 4,
  parameter int DEC_LAT = 1
) (
  input  logic                CLOCK_50,
  input  logic                RESET_N,
  input  logic                load,
  input  logic [4*NDIG-1:0]   din,
  input  logic                lzb,
  output logic                ready,
  output logic                busy,
  output logic                done,
  output logic                drop,
  output logic [3:0]          dec_bcd,
  input  logic [6:0]          dec_seg,
  output logic [7*NDIG-1:0]   hex_all
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int              IW      = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [IW-1:0]   IDX_TOP = IW'(NDIG - 1);
  localparam logic [3:0]      CNT_TOP = 4'(DEC_LAT - 1);
  localparam logic [6:0]      BLANK   = 7'b1111111;

  state_t              state, state_nxt;
  logic [IW-1:0]       idx;
  logic [IW-1:0]       idx_dn;
  logic [3:0]          cnt;
  logic [4*NDIG-1:0]   digits;
  logic                lzb_q;
  logic                seen_nz;
  logic [3:0]          cur_digit;
  logic                capture;
  logic                digit_bad;
  logic                digit_zero;
  logic [6:0]          cap_val;

  assign ready = (state == IDLE);
  assign busy  = (state == RUN) || (state == DONE);
  assign done  = (state == DONE);

  // NOTE: every signal written here gets a default first, so no path leaves a latch.
  always_comb begin
    cur_digit  = digits[4*idx +: 4];
    idx_dn     = idx - 1'b1;
    capture    = (state == RUN) && (cnt == CNT_TOP);
    digit_bad  = (cur_digit > 4'd9);
    digit_zero = (cur_digit == 4'd0);
    cap_val    = dec_seg;
    // Out-of-range codes are blanked so the decoder's undefined output never lands.
    if (digit_bad)
      cap_val = BLANK;
    else if (lzb_q && !seen_nz && digit_zero && (idx != '0))
      cap_val = BLANK;

    state_nxt = state;
    case (state)
      IDLE:    if (load) state_nxt = RUN;
      RUN:     if (capture && (idx == '0)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so all registers
  // update together from pre-edge values.
  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) state <= IDLE;
    else          state <= state_nxt;
  end

  // NOTE: the segment bank is reset explicitly because a blank display after reset
  // is visible behaviour, not just initialisation.
  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      dec_bcd <= 4'd0;
      hex_all <= '1;
      digits  <= '0;
      idx     <= IDX_TOP;
      cnt     <= 4'd0;
      lzb_q   <= 1'b0;
      seen_nz <= 1'b0;
      drop    <= 1'b0;
    end else begin
      drop <= load && (state != IDLE);
      case (state)
        IDLE: begin
          if (load) begin
            digits  <= din;
            lzb_q   <= lzb;
            idx     <= IDX_TOP;
            cnt     <= 4'd0;
            seen_nz <= 1'b0;
            dec_bcd <= din[4*(NDIG-1) +: 4];
          end
        end
        RUN: begin
          if (capture) begin
            hex_all[7*idx +: 7] <= cap_val;
            cnt                 <= 4'd0;
            if (!digit_bad && !digit_zero) seen_nz <= 1'b1;
            if (idx != '0) begin
              idx     <= idx_dn;
              dec_bcd <= digits[4*idx_dn +: 4];
            end
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_scan_ctrl.sv
// Randomized and directed bench for bcd_scan_ctrl; a digit-level model computes the
// expected segment bank and per-cycle scan timing.
module tb_bcd_scan_ctrl;

  localparam int NDIG    = 4;
  localparam int DEC_LAT = 2;
  localparam int LAST    = NDIG * DEC_LAT;

  logic                CLOCK_50 = 1'b0;
  logic                RESET_N  = 1'b0;
  logic                load     = 1'b0;
  logic [4*NDIG-1:0]   din      = '0;
  logic                lzb      = 1'b0;
  logic                ready, busy, done, drop;
  logic [3:0]          dec_bcd;
  logic [6:0]          dec_seg;
  logic [7*NDIG-1:0]   hex_all;

  int total = 0;
  int bad   = 0;
  logic [7*NDIG-1:0] hex_ref = '1;

  always #10 CLOCK_50 = ~CLOCK_50;

  function automatic logic [6:0] seg_of(input logic [3:0] v);
    case (v)
      4'd0: return 7'b0000001;
      4'd1: return 7'b1001111;
      4'd2: return 7'b0010010;
      4'd3: return 7'b0000110;
      4'd4: return 7'b1001100;
      4'd5: return 7'b0100100;
      4'd6: return 7'b0100000;
      4'd7: return 7'b0001111;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0000100;
      default: return 7'bxxxxxxx;
    endcase
  endfunction

  assign dec_seg = seg_of(dec_bcd);

  // Final display contents for one full scan of d, computed digit by digit MSD first.
  function automatic logic [7*NDIG-1:0] scan_ref(input logic [4*NDIG-1:0] d, input logic l);
    logic [7*NDIG-1:0] r;
    logic              seen;
    logic [3:0]        v;
    r    = '1;
    seen = 1'b0;
    for (int i = NDIG - 1; i >= 0; i--) begin
      v = d[4*i +: 4];
      if (v > 9)                           r[7*i +: 7] = 7'b1111111;
      else if (l && !seen && v == 0 && i != 0) r[7*i +: 7] = 7'b1111111;
      else                                 r[7*i +: 7] = seg_of(v);
      if (v != 0 && v <= 9) seen = 1'b1;
    end
    return r;
  endfunction

  bcd_scan_ctrl #(.NDIG(NDIG), .DEC_LAT(DEC_LAT)) dut (
    .CLOCK_50 (CLOCK_50),
    .RESET_N  (RESET_N),
    .load     (load),
    .din      (din),
    .lzb      (lzb),
    .ready    (ready),
    .busy     (busy),
    .done     (done),
    .drop     (drop),
    .dec_bcd  (dec_bcd),
    .dec_seg  (dec_seg),
    .hex_all  (hex_all)
  );

  task automatic tick;
    @(posedge CLOCK_50);
    #1;
  endtask

  // Issues one load and follows the scan edge by edge until ready returns.
  task automatic do_scan(input logic [4*NDIG-1:0] d, input logic l);
    logic [7*NDIG-1:0] fin, exp;
    int j, k, dones;
    fin = scan_ref(d, l);
    total++;
    if (ready !== 1'b1) begin
      bad++; $display("FAIL scan_ready_pre: ready=%b want 1", ready);
    end
    din = d; lzb = l; load = 1'b1;
    tick;
    load = 1'b0; din = 16'($urandom); lzb = 1'($urandom);
    dones = 0;
    for (int e = 0; e <= LAST + 1; e++) begin
      if (e > 0) tick;
      j = (e / DEC_LAT > NDIG) ? NDIG : e / DEC_LAT;
      exp = hex_ref;
      for (int i = 0; i < NDIG; i++)
        if (i >= NDIG - j) exp[7*i +: 7] = fin[7*i +: 7];
      k = (e >= LAST) ? 0 : NDIG - 1 - e / DEC_LAT;
      total++;
      if (hex_all !== exp) begin
        bad++; $display("FAIL scan_hex e=%0d d=%h: hex_all=%h want %h", e, d, hex_all, exp);
      end
      total++;
      if (dec_bcd !== d[4*k +: 4]) begin
        bad++; $display("FAIL scan_dec_bcd e=%0d d=%h: dec_bcd=%h want %h", e, d, dec_bcd, d[4*k +: 4]);
      end
      total++;
      if (done !== (e == LAST)) begin
        bad++; $display("FAIL scan_done e=%0d: done=%b want %b", e, done, (e == LAST));
      end
      total++;
      if (ready !== (e == LAST + 1) || busy !== (e != LAST + 1)) begin
        bad++; $display("FAIL scan_flags e=%0d: ready=%b busy=%b want %b %b",
                        e, ready, busy, (e == LAST + 1), (e != LAST + 1));
      end
      if (done === 1'b1) dones++;
    end
    total++;
    if (dones != 1) begin
      bad++; $display("FAIL scan_done_count: got %0d want 1", dones);
    end
    hex_ref = fin;
  endtask

  task automatic test_reset;
    RESET_N = 1'b0; load = 1'b0;
    repeat (3) tick;
    total++;
    if (hex_all !== 28'hFFFFFFF || ready !== 1'b1 || busy !== 1'b0 ||
        done !== 1'b0 || drop !== 1'b0 || dec_bcd !== 4'd0) begin
      bad++; $display("FAIL reset: hex=%h ready=%b busy=%b done=%b drop=%b dec=%h want FFFFFFF 1 0 0 0 0",
                      hex_all, ready, busy, done, drop, dec_bcd);
    end
    RESET_N = 1'b1;
    tick;
    hex_ref = '1;
  endtask

  task automatic test_basic;
    do_scan(16'h1357, 1'b0);
    total++;
    if (hex_all !== {7'b1001111, 7'b0000110, 7'b0100100, 7'b0001111}) begin
      bad++; $display("FAIL basic_hex: hex_all=%h want %h", hex_all,
                      {7'b1001111, 7'b0000110, 7'b0100100, 7'b0001111});
    end
  endtask

  task automatic test_lzb;
    do_scan(16'h0009, 1'b1);
    total++;
    if (hex_all !== {7'b1111111, 7'b1111111, 7'b1111111, 7'b0000100}) begin
      bad++; $display("FAIL lzb_on: hex_all=%h", hex_all);
    end
    do_scan(16'h0009, 1'b0);
    total++;
    if (hex_all !== {7'b0000001, 7'b0000001, 7'b0000001, 7'b0000100}) begin
      bad++; $display("FAIL lzb_off: hex_all=%h", hex_all);
    end
    do_scan(16'h0000, 1'b1);
    total++;
    if (hex_all[6:0] !== 7'b0000001 || hex_all[27:7] !== 21'h1FFFFF) begin
      bad++; $display("FAIL lzb_all_zero: hex_all=%h", hex_all);
    end
  endtask

  task automatic test_invalid;
    do_scan(16'h9A3F, 1'b0);
    total++;
    if ($isunknown(hex_all) ||
        hex_all !== {7'b0000100, 7'b1111111, 7'b0000110, 7'b1111111}) begin
      bad++; $display("FAIL invalid_digit: hex_all=%h", hex_all);
    end
  endtask

  task automatic test_collision;
    int drops;
    din = 16'h1357; lzb = 1'b0; load = 1'b1;
    tick;
    drops = 0;
    for (int e = 1; e <= LAST + 1; e++) begin
      load = (e == 4);
      din  = (e == 4) ? 16'h2222 : 16'h1357;
      tick;
      total++;
      if (drop !== (e == 4)) begin
        bad++; $display("FAIL collide_drop e=%0d: drop=%b want %b", e, drop, (e == 4));
      end
      if (drop === 1'b1) drops++;
    end
    load = 1'b0;
    total++;
    if (drops != 1 || hex_all !== scan_ref(16'h1357, 1'b0) || ready !== 1'b1) begin
      bad++; $display("FAIL collide_result: drops=%0d hex=%h ready=%b want 1 %h 1",
                      drops, hex_all, ready, scan_ref(16'h1357, 1'b0));
    end
    hex_ref = hex_all === scan_ref(16'h1357, 1'b0) ? scan_ref(16'h1357, 1'b0) : hex_ref;
  endtask

  task automatic test_back_to_back;
    din = 16'h2468; lzb = 1'b0; load = 1'b1;
    tick;
    din = 16'h0024; lzb = 1'b1;
    for (int e = 1; e <= LAST + 1; e++) begin
      tick;
      total++;
      if (drop !== 1'b1 || done !== (e == LAST)) begin
        bad++; $display("FAIL held_load e=%0d: drop=%b done=%b want 1 %b", e, drop, done, (e == LAST));
      end
    end
    total++;
    if (hex_all !== scan_ref(16'h2468, 1'b0)) begin
      bad++; $display("FAIL held_first_hex: hex_all=%h want %h", hex_all, scan_ref(16'h2468, 1'b0));
    end
    tick;
    load = 1'b0;
    total++;
    if (busy !== 1'b1 || drop !== 1'b0 || dec_bcd !== 4'h0) begin
      bad++; $display("FAIL back_to_back_accept: busy=%b drop=%b dec=%h want 1 0 0", busy, drop, dec_bcd);
    end
    for (int e = 1; e <= LAST + 1; e++) tick;
    total++;
    if (hex_all !== scan_ref(16'h0024, 1'b1) || ready !== 1'b1) begin
      bad++; $display("FAIL back_to_back_hex: hex_all=%h ready=%b want %h 1",
                      hex_all, ready, scan_ref(16'h0024, 1'b1));
    end
    hex_ref = scan_ref(16'h0024, 1'b1);
  endtask

  task automatic test_reset_mid;
    int dones;
    din = 16'h9876; lzb = 1'b0; load = 1'b1;
    tick;
    load = 1'b0;
    for (int e = 1; e <= 4; e++) tick;
    RESET_N = 1'b0;
    tick;
    total++;
    if (hex_all !== 28'hFFFFFFF || ready !== 1'b1 || busy !== 1'b0 ||
        done !== 1'b0 || dec_bcd !== 4'd0) begin
      bad++; $display("FAIL reset_mid: hex=%h ready=%b busy=%b done=%b dec=%h",
                      hex_all, ready, busy, done, dec_bcd);
    end
    RESET_N = 1'b1;
    hex_ref = '1;
    dones = 0;
    repeat (2 * LAST) begin
      tick;
      if (done === 1'b1 || ready !== 1'b1) dones++;
    end
    total++;
    if (dones != 0) begin
      bad++; $display("FAIL reset_mid_quiet: %0d cycles with done or !ready, want 0", dones);
    end
    do_scan(16'h0450, 1'b1);
  endtask

  task automatic test_random;
    logic [4*NDIG-1:0] d;
    for (int n = 0; n < 16; n++) begin
      for (int i = 0; i < NDIG; i++)
        d[4*i +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      do_scan(d, 1'($urandom));
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_lzb;
    test_invalid;
    test_collision;
    test_back_to_back;
    test_reset_mid;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bcd_scan_ctrl.md
Name: bcd_scan_ctrl

Overview:
- Scheduler that time-shares one external combinational BCD-to-7-segment decoder among NDIG display digits.
- On each accepted load it latches NDIG BCD digits and feeds them one at a time to the shared decoder, most significant digit first.
- It captures each decoder result into a per-digit segment register and pulses done when every digit is refreshed.
- It sits between the datapath producing BCD values and the HEX display pins.

Parameters:
- NDIG, 4, number of digits sharing the decoder (2..8).
- DEC_LAT, 1, cycles each digit is held on dec_bcd before its result is captured (1..15).

Ports:
- CLOCK_50  input  1  system clock; all logic is rising-edge.
- RESET_N  input  1  synchronous reset, active-low.
- load  input  1  request to latch din and start a scan.
- din  input  4*NDIG  BCD digits; digit i is din[4*i+3:4*i]; digit 0 is least significant.
- lzb  input  1  leading-zero blanking enable, sampled with load.
- ready  output  1  high in IDLE; load is accepted only when ready=1.
- busy  output  1  high while a scan is in progress (RUN or DONE).
- done  output  1  one-cycle pulse after the last digit is captured.
- drop  output  1  one-cycle pulse when load is asserted while ready=0.
- dec_bcd  output  4  BCD value driven to the shared decoder.
- dec_seg  input  7  decoder result; bit 6 = segment a ... bit 0 = segment g; active-low.
- hex_all  output  7*NDIG  captured segments; digit i is hex_all[7*i+6:7*i], same bit order as dec_seg.

Behaviour:
- Reset (RESET_N=0 at a clock edge), with priority over everything else:
  - state=IDLE; ready=1; busy=0; done=0; drop=0.
  - dec_bcd=0; hex_all all ones (all digits blank); internal digit latch=0; idx=NDIG-1; cnt=0.
  - Reset mid-scan aborts the scan; no done is produced.
- States IDLE, RUN, DONE.
- IDLE:
  - load=1 at an edge latches din and lzb, and sets idx=NDIG-1, cnt=0, seen_nz=0.
  - Next state is RUN; ready falls and busy rises in the following cycle.
- RUN:
  - dec_bcd = latched digit[idx] (registered, valid from the first RUN cycle).
  - cnt increments each cycle.
  - At the edge where cnt==DEC_LAT-1, hex_all slice idx is written and cnt resets to 0.
  - If idx>0, idx decrements. If idx==0, next state is DONE.
- Capture value for digit idx, first matching rule wins:
  - digit > 9 -> 7'b1111111 (blank; the decoder's undefined output is never captured).
  - lzb latched = 1, seen_nz = 0, digit == 0, idx != 0 -> 7'b1111111.
  - Otherwise -> dec_seg.
  - seen_nz is set once any captured digit is nonzero and valid (1..9).
- Digit 0 is never leading-zero blanked.
- Slices not yet rescanned hold their previous values; updates become visible digit by digit.
- DONE lasts one cycle with done=1, busy=1, ready=0, then returns to IDLE. dec_bcd holds its last value.
- Latency: accept edge at cycle 0, captures at cycles DEC_LAT, 2*DEC_LAT, ..., NDIG*DEC_LAT; done is high in cycle NDIG*DEC_LAT+1; ready returns in cycle NDIG*DEC_LAT+2.
- Load during RUN or DONE: ignored (din is not sampled, the scan is unaffected) and drop pulses in the next cycle. A load held high is accepted on the first IDLE edge.
- Back-to-back operation: load high in the cycle ready returns is accepted at that edge.
- drop and done are registered one-cycle pulses; they never assert during reset.

Test Plan (NDIG=4, DEC_LAT=2, bench model of the decoder from the team's BCD table: 0->0000001, 1->1001111, 3->0000110, 5->0100100, 7->0001111, 9->0000100; all others per that table):
1. Reset: hold RESET_N=0 for 3 cycles -> hex_all=28'hFFFFFFF, ready=1, busy=0, done=0, dec_bcd=0.
2. Basic scan: load with din=16'h1357, lzb=0.
   - dec_bcd = 1, 3, 5, 7, two cycles each.
   - hex_all = {1001111, 0000110, 0100100, 0001111}.
   - done high exactly in cycle 9 after the accept edge; ready high in cycle 10.
3. Leading-zero blanking: din=16'h0009, lzb=1 -> slices 3..1 = 1111111, slice 0 = 0000100.
   - Repeat with lzb=0 -> slices 3..1 = 0000001.
   - din=16'h0000, lzb=1 -> slice 0 = 0000001.
4. Invalid digit: din=16'h9A3F with the bench decoder driving X for values above 9 -> slices 2 and 0 = 1111111, slice 3 = 0000100, slice 1 = 0000110; no X ever appears on hex_all.
5. Busy collision: second load with din=16'h2222 in cycle 4 of a scan -> drop pulses once; final hex_all reflects the first din only.
   - A load held high until ready returns starts a second scan at that edge.
6. Reset mid-scan: RESET_N=0 in cycle 5 of a scan -> next cycle hex_all=all ones, state IDLE, no done pulse.
   - A fresh load then completes normally.
